sdram_port_arbiter: RTL and testbench

Shares the single SDRAM controller port (read/write/addr/writedata/readdata/finished handshake) between up to N requesters, e.g. recorder, player and PitchCore. Requests are granted round-robin, one transaction at a time. The arbiter forwards the granted requester's command and routes the finished pulse and read data back. A watchdog aborts transactions the SDRAM side never completes.

---
 rtl/sdram_arb_pkg.sv | 28 ++
 rtl/rr_pick.sv | 30 +++
 rtl/sdram_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

   // Default widths of the SDRAM controller port.
   localparam int unsigned DEF_ADDR_W = 23;
   localparam int unsigned DEF_DATA_W = 32;

   // Arbiter states.
   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RELEASE
   } arb_state_e;

   // One SDRAM command at the default port widths.
   typedef struct packed {
      logic                  read;
      logic                  write;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
   } arb_cmd_t;

   // $clog2 clamped to at least one bit, so that degenerate parameters still give legal vectors.
   function automatic int unsigned clog2_min1(input int unsigned value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first pending index at or after the pointer, searching cyclically.
module rr_pick
   import sdram_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 3,
   parameter int unsigned PTR_W = clog2_min1(N_REQ)
) (
   input  logic [N_REQ-1:0] i_pending,
   input  logic [PTR_W-1:0] i_ptr,
   output logic             o_valid,
   output logic [PTR_W-1:0] o_idx
);

   logic [PTR_W-1:0] w_cand;

   // Walk the candidates farthest-first so the one nearest the pointer is written last and wins.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      w_cand  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_cand = PTR_W'((int'(i_ptr) + k) % N_REQ);
         if (i_pending[w_cand]) begin
            o_valid = 1'b1;
            o_idx   = w_cand;
         end
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between N_REQ requesters, one transaction at a time,
// granted round-robin, with a watchdog that aborts transactions the controller never finishes.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned N_REQ   = 3,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   // requester side
   input  logic [N_REQ-1:0]        req_read,
   input  logic [N_REQ-1:0]        req_write,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*DATA_W-1:0] req_writedata,
   output logic [DATA_W-1:0]       req_readdata,
   output logic [N_REQ-1:0]        req_finished,
   output logic [N_REQ-1:0]        req_error,
   // controller side
   output logic                    sdram_read,
   output logic                    sdram_write,
   output logic [ADDR_W-1:0]       sdram_addr,
   output logic [DATA_W-1:0]       sdram_writedata,
   input  logic [DATA_W-1:0]       sdram_readdata,
   input  logic                    sdram_finished,
   // current owner, one-hot
   output logic [N_REQ-1:0]        grant
);

   localparam int unsigned PTR_W = clog2_min1(N_REQ);
   localparam int unsigned WD_W  = clog2_min1(TIMEOUT + 1);
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

   // Command latched at grant time; it directly drives the controller outputs.
   typedef struct packed {
      logic              read;
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   arb_state_e       r_state,  w_state_nxt;
   cmd_t             r_cmd,    w_cmd_nxt;
   logic [PTR_W-1:0] r_gidx,   w_gidx_nxt;
   logic [N_REQ-1:0] r_grant,  w_grant_nxt;
   logic [PTR_W-1:0] r_rr_ptr, w_rr_nxt;
   logic [WD_W-1:0]  r_wd,     w_wd_nxt;
   logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
   logic [N_REQ-1:0] r_fin,    w_fin_nxt;
   logic [N_REQ-1:0] r_err,    w_err_nxt;

   logic [N_REQ-1:0]  w_pending;
   logic              w_pick_valid;
   logic [PTR_W-1:0]  w_pick_idx;
   logic              w_sel_rd;
   logic              w_sel_wr;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_data;
   logic [N_REQ-1:0]  w_sel_onehot;
   logic [PTR_W-1:0]  w_rr_after;

   assign w_pending = req_read | req_write;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .i_pending (w_pending),
      .i_ptr     (r_rr_ptr),
      .o_valid   (w_pick_valid),
      .o_idx     (w_pick_idx)
   );

   // Select the picked requester's command fields and one-hot grant.
   always_comb begin
      w_sel_rd     = 1'b0;
      w_sel_wr     = 1'b0;
      w_sel_addr   = '0;
      w_sel_data   = '0;
      w_sel_onehot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_pick_idx == PTR_W'(i)) begin
            w_sel_rd        = req_read[i];
            w_sel_wr        = req_write[i];
            w_sel_addr      = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_data      = req_writedata[i*DATA_W +: DATA_W];
            w_sel_onehot[i] = 1'b1;
         end
      end
   end

   // Pointer after the current owner, wrapping explicitly for non-power-of-2 N_REQ.
   assign w_rr_after = (r_gidx == LAST_IDX) ? '0 : r_gidx + PTR_W'(1);

   // Next-state and registered-output logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cmd_nxt   = r_cmd;
      w_gidx_nxt  = r_gidx;
      w_grant_nxt = r_grant;
      w_rr_nxt    = r_rr_ptr;
      w_wd_nxt    = r_wd;
      w_rdata_nxt = r_rdata;
      w_fin_nxt   = '0;
      w_err_nxt   = '0;

      unique case (r_state)
         IDLE: begin
            w_cmd_nxt   = '0;
            w_grant_nxt = '0;
            if (w_pick_valid) begin
               w_state_nxt     = BUSY;
               w_gidx_nxt      = w_pick_idx;
               w_grant_nxt     = w_sel_onehot;
               w_wd_nxt        = '0;
               // read+write together is served as a write
               w_cmd_nxt.write = w_sel_wr;
               w_cmd_nxt.read  = w_sel_rd & ~w_sel_wr;
               w_cmd_nxt.addr  = w_sel_addr;
               w_cmd_nxt.wdata = w_sel_data;
            end
         end

         BUSY: begin
            if (r_wd != WD_LIMIT) begin
               w_wd_nxt = r_wd + WD_W'(1);
            end
            // a completion in the same cycle as the limit still counts as a completion
            if (sdram_finished || (r_wd == WD_LIMIT)) begin
               w_fin_nxt   = r_grant;
               w_rr_nxt    = w_rr_after;
               w_cmd_nxt   = '0;
               w_grant_nxt = '0;
               w_state_nxt = RELEASE;
               if (!sdram_finished) begin
                  w_err_nxt   = r_grant;
                  w_rdata_nxt = '0;
               end else if (r_cmd.read) begin
                  w_rdata_nxt = sdram_readdata;
               end
            end
         end

         RELEASE: begin
            // one quiet cycle lets the served requester drop its request before re-arbitration
            w_cmd_nxt   = '0;
            w_grant_nxt = '0;
            w_state_nxt = IDLE;
         end

         default: begin
            w_cmd_nxt   = '0;
            w_grant_nxt = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_cmd    <= '0;
         r_gidx   <= '0;
         r_grant  <= '0;
         r_rr_ptr <= '0;
         r_wd     <= '0;
         r_rdata  <= '0;
         r_fin    <= '0;
         r_err    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cmd    <= w_cmd_nxt;
         r_gidx   <= w_gidx_nxt;
         r_grant  <= w_grant_nxt;
         r_rr_ptr <= w_rr_nxt;
         r_wd     <= w_wd_nxt;
         r_rdata  <= w_rdata_nxt;
         r_fin    <= w_fin_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign sdram_read      = r_cmd.read;
   assign sdram_write     = r_cmd.write;
   assign sdram_addr      = r_cmd.addr;
   assign sdram_writedata = r_cmd.wdata;
   assign req_readdata    = r_rdata;
   assign req_finished    = r_fin;
   assign req_error       = r_err;
   assign grant           = r_grant;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios followed by random traffic,
// all outputs compared every cycle against a transaction-level reference model.
module tb_sdram_port_arbiter;

   localparam int N  = 3;
   localparam int AW = 23;
   localparam int DW = 32;
   localparam int TO = 15;

   logic            i_clk = 1'b0;
   logic            i_rst_n = 1'b0;
   logic [N-1:0]    req_read = '0;
   logic [N-1:0]    req_write = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_writedata = '0;
   logic [DW-1:0]   req_readdata;
   logic [N-1:0]    req_finished;
   logic [N-1:0]    req_error;
   logic            sdram_read;
   logic            sdram_write;
   logic [AW-1:0]   sdram_addr;
   logic [DW-1:0]   sdram_writedata;
   logic [DW-1:0]   sdram_readdata = '0;
   logic            sdram_finished = 1'b0;
   logic [N-1:0]    grant;

   always #5 i_clk = ~i_clk;

   sdram_port_arbiter #(
      .N_REQ   (N),
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .req_read        (req_read),
      .req_write       (req_write),
      .req_addr        (req_addr),
      .req_writedata   (req_writedata),
      .req_readdata    (req_readdata),
      .req_finished    (req_finished),
      .req_error       (req_error),
      .sdram_read      (sdram_read),
      .sdram_write     (sdram_write),
      .sdram_addr      (sdram_addr),
      .sdram_writedata (sdram_writedata),
      .sdram_readdata  (sdram_readdata),
      .sdram_finished  (sdram_finished),
      .grant           (grant)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // reference model: owner of the transaction in flight, or -1
   int            m_owner = -1;
   bit            m_release = 1'b0;
   int            m_ptr = 0;
   int            m_age = 0;
   logic [DW-1:0] m_rdata = '0;
   bit            m_rd, m_wr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [N-1:0]  e_grant, e_fin, e_err;

   // inputs as presented to the DUT at the coming edge
   logic [N-1:0]    p_rd, p_wr;
   logic [N*AW-1:0] p_addr;
   logic [N*DW-1:0] p_wd;
   logic            p_fin, p_rst_n;
   logic [DW-1:0]   p_rdata;

   // controller model
   logic [DW-1:0] mem [int];
   int ctl_lat = 2;
   bit ctl_never = 1'b0;
   bit ctl_seen = 1'b0;
   bit ctl_active = 1'b0;
   int ctl_cnt = 0;
   bit stray = 1'b0;
   bit rand_mode = 1'b0;

   // observations
   int            obs_q[$];
   bit            g_prev = 1'b0;
   bit            c_rd, c_wr;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_data;
   int            c_cycle = 0;
   int            fin_cycle = 0;
   int            err_cycle = 0;
   int            fin_count = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      v = 32'hA5A5_0000 ^ DW'(a);
      if (mem.exists(int'(a))) v = mem[int'(a)];
      return v;
   endfunction

   // Arbitration rules applied to the inputs seen at the edge just taken.
   function automatic void model_edge();
      e_fin = '0;
      e_err = '0;
      if (!p_rst_n) begin
         m_owner = -1; m_release = 1'b0; m_ptr = 0; m_rdata = '0;
      end else if (m_release) begin
         m_release = 1'b0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (m_owner < 0 && (p_rd[j] || p_wr[j])) m_owner = j;
         end
         if (m_owner >= 0) begin
            m_wr    = p_wr[m_owner];
            m_rd    = p_rd[m_owner] && !p_wr[m_owner];
            m_addr  = p_addr[m_owner*AW +: AW];
            m_wdata = p_wd[m_owner*DW +: DW];
            m_age   = 0;
         end
      end else if (p_fin || m_age == TO) begin
         e_fin[m_owner] = 1'b1;
         if (!p_fin) begin
            e_err[m_owner] = 1'b1;
            m_rdata = '0;
         end else if (m_rd) begin
            m_rdata = p_rdata;
         end
         m_ptr = (m_owner + 1) % N;
         m_owner = -1;
         m_release = 1'b1;
      end else begin
         m_age++;
      end
      e_grant = '0;
      if (m_owner >= 0) e_grant[m_owner] = 1'b1;
   endfunction

   task automatic set_req(input int i, input bit rd, input bit wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_read[i] = rd;
      req_write[i] = wr;
      req_addr[i*AW +: AW] = a;
      req_writedata[i*DW +: DW] = d;
   endtask

   task automatic requesters_react();
      for (int i = 0; i < N; i++) begin
         if (req_finished[i]) begin
            req_read[i] = 1'b0;
            req_write[i] = 1'b0;
         end else if (rand_mode) begin
            if (!(req_read[i] || req_write[i])) begin
               if ($urandom_range(0, 3) == 0) begin
                  int kind = $urandom_range(0, 9);
                  set_req(i, kind < 6, kind == 0 || kind >= 6, AW'($urandom), $urandom);
               end
            end else if (m_owner != i && $urandom_range(0, 19) == 0) begin
               req_read[i] = 1'b0;
               req_write[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic controller_react();
      if (!p_rst_n) begin
         ctl_active = 1'b0;
         ctl_seen = 1'b0;
      end
      sdram_finished = 1'b0;
      sdram_readdata = $urandom;
      if (!(sdram_read || sdram_write)) ctl_seen = 1'b0;
      if (!ctl_seen && (sdram_read || sdram_write)) begin
         bit skip = ctl_never;
         ctl_seen = 1'b1;
         if (rand_mode) begin
            int v = $urandom_range(0, 8);
            ctl_lat = (v > 6) ? 14 + (v - 7) : v;
            skip = ($urandom_range(0, 11) == 0);
         end
         if (!skip) begin
            ctl_active = 1'b1;
            ctl_cnt = ctl_lat;
         end
      end
      if (ctl_active) begin
         if (ctl_cnt == 0) begin
            sdram_finished = 1'b1;
            ctl_active = 1'b0;
            if (sdram_write) mem[int'(sdram_addr)] = sdram_writedata;
            else sdram_readdata = mem_rd(sdram_addr);
         end else begin
            ctl_cnt--;
         end
      end
      if (stray) sdram_finished = 1'b1;
   endtask

   // One clock: advance, compare every output with the model, then drive the next inputs.
   task automatic step();
      p_rd = req_read; p_wr = req_write; p_addr = req_addr; p_wd = req_writedata;
      p_fin = sdram_finished; p_rdata = sdram_readdata; p_rst_n = i_rst_n;
      @(posedge i_clk);
      #1;
      cyc++;
      model_edge();
      chk("grant", 64'(grant), 64'(e_grant));
      chk("req_finished", 64'(req_finished), 64'(e_fin));
      chk("req_error", 64'(req_error), 64'(e_err));
      chk("req_readdata", 64'(req_readdata), 64'(m_rdata));
      chk("sdram_read", 64'(sdram_read), 64'(m_owner >= 0 ? m_rd : 1'b0));
      chk("sdram_write", 64'(sdram_write), 64'(m_owner >= 0 ? m_wr : 1'b0));
      chk("sdram_addr", 64'(sdram_addr), 64'(m_owner >= 0 ? m_addr : '0));
      chk("sdram_writedata", 64'(sdram_writedata), 64'(m_owner >= 0 ? m_wdata : '0));
      if (grant != '0 && !g_prev) begin
         c_rd = sdram_read; c_wr = sdram_write; c_addr = sdram_addr; c_data = sdram_writedata;
         c_cycle = cyc;
      end
      g_prev = (grant != '0);
      for (int i = 0; i < N; i++) if (req_finished[i]) obs_q.push_back(i);
      if (req_finished != '0) begin
         fin_cycle = cyc;
         fin_count++;
      end
      if (req_error != '0) err_cycle = cyc;
      requesters_react();
      controller_react();
   endtask

   task automatic wait_fin(input int i, input int budget);
      int n = 0;
      do begin
         step();
         n++;
      end while (!req_finished[i] && n < budget);
      chk("wait_fin", 64'(req_finished[i]), 64'(1));
   endtask

   task automatic wait_obs(input int count, input int budget);
      int n = 0;
      while (obs_q.size() < count && n < budget) begin
         step();
         n++;
      end
      chk("wait_obs", 64'(obs_q.size()), 64'(count));
   endtask

   initial begin
      int fc;
      int exp_order[4];
      logic [DW-1:0] rd_before;

      // reset state
      step();
      step();
      chk("reset_grant", 64'(grant), 64'(0));
      i_rst_n = 1'b1;
      step();

      // single read
      mem[32'h100] = 32'hDEAD_BEEF;
      ctl_lat = 4;
      set_req(1, 1'b1, 1'b0, 23'h000100, 32'h0);
      wait_fin(1, 30);
      chk("single_cmd_rd", 64'(c_rd), 64'(1));
      chk("single_cmd_addr", 64'(c_addr), 64'(23'h000100));
      chk("single_latency", 64'(fin_cycle - c_cycle), 64'(5));
      chk("single_rdata", 64'(req_readdata), 64'(32'hDEAD_BEEF));
      step();
      chk("single_release", 64'(sdram_read), 64'(0));
      step();

      // contention from rr_ptr = 0, then a wrap back to requester 0
      i_rst_n = 1'b0;
      step();
      i_rst_n = 1'b1;
      ctl_lat = 2;
      obs_q.delete();
      set_req(0, 1'b1, 1'b0, 23'h10, 32'h0);
      set_req(1, 1'b1, 1'b0, 23'h20, 32'h0);
      set_req(2, 1'b1, 1'b0, 23'h30, 32'h0);
      wait_fin(0, 30);
      step();
      set_req(0, 1'b1, 1'b0, 23'h40, 32'h0);
      wait_obs(4, 200);
      exp_order = '{0, 1, 2, 0};
      for (int k = 0; k < 4; k++) chk("rr_order", 64'(obs_q[k]), 64'(exp_order[k]));
      step();

      // write path
      rd_before = req_readdata;
      set_req(2, 1'b0, 1'b1, 23'h7FFFFF, 32'h1234_5678);
      wait_fin(2, 30);
      chk("write_cmd_wr", 64'(c_wr), 64'(1));
      chk("write_cmd_rd", 64'(c_rd), 64'(0));
      chk("write_addr", 64'(c_addr), 64'(23'h7FFFFF));
      chk("write_data", 64'(c_data), 64'(32'h1234_5678));
      chk("write_rdata_kept", 64'(req_readdata), 64'(rd_before));
      step();

      // timeout
      ctl_never = 1'b1;
      set_req(0, 1'b1, 1'b0, 23'h55, 32'h0);
      wait_fin(0, 40);
      chk("timeout_err", 64'(req_error[0]), 64'(1));
      chk("timeout_delay", 64'(err_cycle - c_cycle), 64'(TO + 1));
      chk("timeout_rdata", 64'(req_readdata), 64'(0));
      ctl_never = 1'b0;
      step();
      obs_q.delete();
      set_req(0, 1'b1, 1'b0, 23'h66, 32'h0);
      set_req(1, 1'b1, 1'b0, 23'h77, 32'h0);
      wait_obs(1, 30);
      chk("timeout_ptr_next", 64'(obs_q[0]), 64'(1));
      wait_obs(2, 40);
      step();

      // reset during a read, then a stray finished pulse
      ctl_lat = 8;
      set_req(1, 1'b1, 1'b0, 23'h88, 32'h0);
      step();
      step();
      chk("rst_busy_grant", 64'(grant), 64'(3'b010));
      step();
      i_rst_n = 1'b0;
      req_read = '0;
      req_write = '0;
      step();
      chk("rst_outputs", 64'({grant, req_finished, req_error, sdram_read, sdram_write}), 64'(0));
      i_rst_n = 1'b1;
      fc = fin_count;
      step();
      step();
      stray = 1'b1;
      step();
      stray = 1'b0;
      step();
      step();
      chk("stray_no_pulse", 64'(fin_count), 64'(fc));

      // read and write together
      ctl_lat = 1;
      set_req(0, 1'b1, 1'b1, 23'h99, 32'hCAFE_F00D);
      wait_fin(0, 30);
      chk("rw_both_wr", 64'(c_wr), 64'(1));
      chk("rw_both_rd", 64'(c_rd), 64'(0));
      step();

      // random traffic
      rand_mode = 1'b1;
      for (int n = 0; n < 2000; n++) step();
      rand_mode = 1'b0;
      for (int n = 0; n < 80; n++) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
